imem_loader: RTL and testbench
==============================

# imem_loader

Boot loader for the 16-bit single-cycle processor. It accepts a byte stream over a valid/ready handshake, assembles bytes into 16-bit instruction words (high byte first) and writes them into consecutive instruction-memory locations. It verifies an XOR checksum byte and holds the processor in reset until a complete, verified program is resident. It is the write side of the instruction memory, which the processor only reads via `pc`.

## Interface
- `ADDR_W`, 3: instruction-memory address width; matches the 3-bit `pc`.
- `DEPTH`, 8: words per load, equal to 2**ADDR_W.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: begin a load; sampled only in IDLE, DONE and ERR.
- `in_valid` input 1: `in_data` holds a byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `wr_en` output 1: instruction-memory write strobe.
- `wr_addr` output ADDR_W: write address.
- `wr_data` output 16: instruction word to write.
- `cpu_rst` output 1: processor reset; drives the processor's `rst`.
- `done` output 1: program loaded and checksum matched.
- `err` output 1: checksum mismatch on last load.

## Operation
- A handshake occurs on any rising edge with `in_valid & in_ready`. No byte is consumed otherwise.
- Internal state: FSM, word counter `cnt` (ADDR_W bits), high-byte register `hi`, running checksum `chk` (8 bits, XOR of every accepted data byte).
- States:
  - IDLE: `in_ready`=0. `start`=1 moves to HI and clears `cnt`, `chk`, `err` and `done`.
  - HI: `in_ready`=1. On handshake: `hi`<=byte, `chk`<=`chk`^byte, go to LO.
  - LO: `in_ready`=1. On handshake: `wr_data`<={`hi`,byte}, `wr_addr`<=`cnt`, `chk`<=`chk`^byte, go to WRITE.
  - WRITE: `in_ready`=0, `wr_en`=1 for exactly this cycle.
    - If `cnt`==DEPTH-1, go to CHK.
    - Otherwise `cnt`<=`cnt`+1 and go to HI.
  - CHK: `in_ready`=1. On handshake:
    - Byte equal to `chk`: go to DONE.
    - Otherwise: go to ERR.
  - DONE: `done`=1, `cpu_rst`=0. `start`=1 moves to HI with the same clears as IDLE.
  - ERR: `err`=1, `cpu_rst`=1. `start`=1 moves to HI with the same clears as IDLE.
- `cpu_rst`=1 in every state except DONE.
- `start` is ignored in HI, LO, WRITE and CHK.
- `cnt` never wraps mid-load: the DEPTH-1 check precedes any increment.
- A partial load leaves earlier-written words in memory. The loader never clears memory.
- Reset mid-operation: FSM goes to IDLE immediately, all registers clear, and any in-flight word is dropped without a write.

## Timing
- Reset values:
  - State: IDLE.
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `cpu_rst`=1, `done`=0, `err`=0.
  - `cnt`=0, `hi`=0, `chk`=0.
- All outputs are registered or Moore decodes of the registered state. There is no combinational path from `in_valid` or `start` to any output.
- Latency:
  - The `start` edge moves the FSM to HI; `in_ready` is high from the next cycle.
  - The LO handshake edge moves the FSM to WRITE; `wr_en`, `wr_addr` and `wr_data` are valid and stable for that one cycle.
  - `wr_data`/`wr_addr` hold their values after WRITE until the next LO handshake.
  - The CHK handshake edge moves the FSM to DONE/ERR; `done`/`cpu_rst`/`err` change in the following cycle.
- Minimum load with no stalls: 1 `start` cycle, then 3*DEPTH cycles, then 1 CHK cycle. That is 26 cycles for DEPTH=8.
- `in_valid` may drop for any number of cycles. The FSM waits in the current state and never accepts a byte while `in_ready`=0.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle, no clock. Outputs reach their reset values immediately: `cpu_rst`=1, `in_ready`=0, `wr_en`=0, `done`=0, `err`=0.
- **Good load:** `start`, then bytes 10 00 10 01 … 10 07 and checksum 00, no stalls.
  - Exactly 8 single-cycle `wr_en` pulses, `wr_addr` 0..7 with `wr_data` 0x1000..0x1007.
  - `done`=1 and `cpu_rst`=0 on cycle 27 after `start`.
- **Bad checksum:** same stream with checksum 5A.
  - All 8 writes still occur.
  - `err`=1, `done`=0, `cpu_rst` stays 1.
  - A new `start` gives `err`=0 on the next cycle.
- **Backpressure:** same good stream with `in_valid` deasserted on random cycles and held during WRITE.
  - Identical writes and final `done`=1.
  - No byte is consumed while `in_ready`=0.
- **Start handling:** `start` pulsed in HI, LO, WRITE and CHK is ignored and the load completes normally. `start` in DONE gives `cpu_rst`=1 and `done`=0 on the next cycle, then a fresh load writes from address 0.
- **Reset mid-load:** assert `rst` after 3 words plus a high byte.
  - No further `wr_en` pulses.
  - After release the state is IDLE with `in_ready`=0.
  - A subsequent good load completes with `done`=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles a byte stream into 16-bit words, writes them to instruction
// memory, verifies an XOR checksum and holds the processor in reset until a good load.
module imem_loader #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [ADDR_W-1:0] r_cnt;
   logic [7:0]        r_hi;
   logic [7:0]        r_chk;
   logic              w_hs;

   assign w_hs = in_valid & in_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   // Next-state logic
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (start) w_state_nx = S_HI;
         S_HI:    if (w_hs) w_state_nx = S_LO;
         S_LO:    if (w_hs) w_state_nx = S_WRITE;
         S_WRITE: w_state_nx = (r_cnt == LAST_ADDR) ? S_CHK : S_HI;
         S_CHK:   if (w_hs) w_state_nx = (in_data == r_chk) ? S_DONE : S_ERR;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Datapath: word counter, high byte, running checksum and write payload
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_hi    <= '0;
         r_chk   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_cnt <= '0;
                  r_chk <= '0;
               end
            end
            S_HI: begin
               if (w_hs) begin
                  r_hi  <= in_data;
                  r_chk <= r_chk ^ in_data;
               end
            end
            S_LO: begin
               if (w_hs) begin
                  wr_data <= {r_hi, in_data};
                  wr_addr <= r_cnt;
                  r_chk   <= r_chk ^ in_data;
               end
            end
            S_WRITE: begin
               if (r_cnt != LAST_ADDR) r_cnt <= r_cnt + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Status outputs registered from the next state so they track the FSM exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         cpu_rst  <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         in_ready <= (w_state_nx == S_HI) || (w_state_nx == S_LO) || (w_state_nx == S_CHK);
         wr_en    <= (w_state_nx == S_WRITE);
         cpu_rst  <= (w_state_nx != S_DONE);
         done     <= (w_state_nx == S_DONE);
         err      <= (w_state_nx == S_ERR);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte streams in, observed memory writes and
// status compared against a word/checksum model built from the stream itself.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DEPTH  = 8;
   localparam int          NBYTES = 2 * DEPTH + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              cpu_rst;
   logic              done;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_rst(cpu_rst), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned c0      = 0;
   int          dbl     = 0;
   logic        prev_wr = 1'b0;
   logic [7:0]  stream[$];
   logic [ADDR_W+15:0] wq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Record every write strobe and flag any strobe longer than one cycle
   always @(negedge clk) begin
      if (wr_en) wq.push_back({wr_addr, wr_data});
      if (wr_en && prev_wr) dbl = dbl + 1;
      prev_wr = wr_en;
   end

   // Build DEPTH words plus a checksum byte; fixed pattern is 10 00 .. 10 07
   task automatic build_stream(input bit rnd, input bit good);
      logic [7:0] x;
      x = 8'h00;
      stream.delete();
      for (int k = 0; k < int'(DEPTH); k++) begin
         stream.push_back(rnd ? 8'($urandom) : 8'h10);
         stream.push_back(rnd ? 8'($urandom) : 8'(k));
      end
      foreach (stream[i]) x = x ^ stream[i];
      stream.push_back(good ? x : (x ^ 8'h5A));
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c0 = cyc;
   endtask

   task automatic send_bytes(input int n, input bit stall, input bit noise, input string name);
      bit hs;
      int budget;
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         hs = 1'b0;
         budget = 0;
         while (!hs && budget < 50) begin
            @(negedge clk);
            in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = stream[i];
            if (noise) start = ($urandom_range(0, 3) == 0);
            hs = in_valid && in_ready;
            @(posedge clk);
            budget++;
         end
         if (!hs) ok = 1'b0;
      end
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
      n_tests++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s handshake timeout: got ok=%0b want 1", name, ok);
      end
   endtask

   task automatic check_writes(input string name);
      logic [ADDR_W+15:0] exp;
      n_tests++;
      if (wq.size() !== int'(DEPTH)) begin
         n_fail++;
         $display("FAIL %s write count: got %0d want %0d", name, wq.size(), DEPTH);
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            exp = {ADDR_W'(k), stream[2*k], stream[2*k+1]};
            n_tests++;
            if (wq[k] !== exp) begin
               n_fail++;
               $display("FAIL %s write %0d: got %h want %h", name, k, wq[k], exp);
            end
         end
      end
      n_tests++;
      if (dbl !== 0) begin
         n_fail++;
         $display("FAIL %s wr_en pulse width: got %0d long pulses want 0", name, dbl);
      end
   endtask

   task automatic check_status(input string name, input bit exp_done);
      @(negedge clk);
      n_tests++;
      if ({done, err, cpu_rst} !== {exp_done, ~exp_done, ~exp_done}) begin
         n_fail++;
         $display("FAIL %s status done/err/cpu_rst: got %b%b%b want %b%b%b", name,
                  done, err, cpu_rst, exp_done, ~exp_done, ~exp_done);
      end
   endtask

   task automatic run_load(input bit rnd, input bit good, input bit stall, input bit noise,
                           input string name);
      build_stream(rnd, good);
      wq.delete();
      dbl = 0;
      do_start();
      send_bytes(NBYTES, stall, noise, name);
      check_status(name, good);
      check_writes(name);
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({cpu_rst, in_ready, wr_en, done, err} !== 5'b10000 || wr_addr !== '0 || wr_data !== '0) begin
         n_fail++;
         $display("FAIL reset values: got cpu_rst=%b rdy=%b wr=%b done=%b err=%b addr=%h data=%h want 1 0 0 0 0 0 0",
                  cpu_rst, in_ready, wr_en, done, err, wr_addr, wr_data);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle in_ready: got %b want 0", in_ready);
      end
   endtask

   task automatic test_good_load();
      build_stream(1'b0, 1'b1);
      wq.delete();
      dbl = 0;
      do_start();
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start latency in_ready: got %b want 1", in_ready);
      end
      send_bytes(NBYTES, 1'b0, 1'b0, "good");
      check_status("good", 1'b1);
      n_tests++;
      if (cyc - c0 !== 25) begin
         n_fail++;
         $display("FAIL good latency: got %0d edges after start want 25", cyc - c0);
      end
      check_writes("good");
   endtask

   task automatic test_bad_checksum();
      run_load(1'b0, 1'b0, 1'b0, 1'b0, "bad_chk");
      run_load(1'b1, 1'b0, 1'b1, 1'b0, "bad_chk_rnd");
      do_start();
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL restart after err: got err=%b want 0", err);
      end
      build_stream(1'b1, 1'b1);
      wq.delete();
      dbl = 0;
      send_bytes(NBYTES, 1'b0, 1'b0, "err_restart");
      check_status("err_restart", 1'b1);
      check_writes("err_restart");
   endtask

   task automatic test_backpressure();
      run_load(1'b0, 1'b1, 1'b1, 1'b0, "bp_fixed");
      for (int r = 0; r < 3; r++) run_load(1'b1, 1'b1, 1'b1, 1'b0, "bp_rnd");
   endtask

   task automatic test_start_handling();
      run_load(1'b1, 1'b1, 1'b1, 1'b1, "start_noise");
      do_start();
      n_tests++;
      if ({cpu_rst, done} !== 2'b10) begin
         n_fail++;
         $display("FAIL start from done: got cpu_rst=%b done=%b want 1 0", cpu_rst, done);
      end
      build_stream(1'b1, 1'b1);
      wq.delete();
      dbl = 0;
      send_bytes(NBYTES, 1'b0, 1'b1, "reload");
      check_status("reload", 1'b1);
      check_writes("reload");
   endtask

   task automatic test_reset_mid_load();
      build_stream(1'b1, 1'b1);
      wq.delete();
      dbl = 0;
      do_start();
      send_bytes(7, 1'b0, 1'b0, "mid_rst");
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({in_ready, wr_en, cpu_rst, done} !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid reset outputs: got rdy=%b wr=%b cpu_rst=%b done=%b want 0 0 1 0",
                  in_ready, wr_en, cpu_rst, done);
      end
      in_valid = 1'b1;
      in_data  = stream[7];
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL after reset in_ready: got %b want 0", in_ready);
      end
      in_valid = 1'b0;
      n_tests++;
      if (wq.size() !== 3) begin
         n_fail++;
         $display("FAIL mid reset write count: got %0d want 3", wq.size());
      end
      run_load(1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_backpressure();
      test_start_handling();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
